// File: rtl/sfq_and_driver.sv
// sfq_and_driver
//   Digital-side stimulus/response driver for a toggle-encoded SFQ clocked
//   AND gate. It accepts one (a, b) operand pair per handshake. It emits
//   toggle-encoded pulses on the gate's a, b and clock lines, separated by
//   programmable cycle counts. It then counts gate-output toggles inside a
//   response window and reports the decoded result against the expected AND.
//
// Parameters
//   AB_SEP_CYC  cycles from the sfq_a slot to the sfq_b slot   (1..255)
//   SETUP_CYC   cycles from the sfq_b slot to the sfq_clk toggle (1..255)
//   RESP_CYC    response-window length after sfq_clk            (1..255)
//
// Ports
//   clk, rst            sampling clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (accept on both high at posedge)
//   in_a, in_b          operands
//   sfq_a/sfq_b/sfq_clk toggle-encoded pulse lines to the gate
//   sfq_out             toggle-encoded gate output (asynchronous to clk)
//   res_valid           one-cycle result strobe
//   res_out/res_exp     decoded gate result / expected in_a & in_b
//   res_err             mismatch, multiple toggles, or a spurious toggle
//   err_sticky          set by any res_err, cleared only by rst
module sfq_and_driver #(
  parameter int unsigned AB_SEP_CYC = 5,
  parameter int unsigned SETUP_CYC  = 8,
  parameter int unsigned RESP_CYC   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_a,
  input  logic in_b,
  output logic sfq_a,
  output logic sfq_b,
  output logic sfq_clk,
  input  logic sfq_out,
  output logic res_valid,
  output logic res_out,
  output logic res_exp,
  output logic res_err,
  output logic err_sticky
);

  localparam logic [7:0] AB_LOAD    = 8'(AB_SEP_CYC);
  localparam logic [7:0] SETUP_LOAD = 8'(SETUP_CYC);
  localparam logic [7:0] RESP_LOAD  = 8'(RESP_CYC);

  typedef enum logic [2:0] {
    IDLE, PULSE_A, GAP_B, GAP_CLK, WINDOW, REPORT
  } state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       a_q, b_q;
  logic       out_q;
  logic [1:0] tog_cnt, tog_cnt_nx;
  logic       spur, spur_nx;

  logic       accept, expired, toggle;
  logic       fire_a, fire_b, fire_clk, finish;
  logic       out_nx, exp_nx, err_nx;

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign expired  = (cnt == 8'd1);
  assign toggle   = (sfq_out != out_q);

  // NOTE: every signal gets a default before the case so that no path leaves
  // it unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    fire_a   = 1'b0;
    fire_b   = 1'b0;
    fire_clk = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = PULSE_A;
      PULSE_A: begin
        fire_a   = a_q;
        cnt_nx   = AB_LOAD;
        state_nx = GAP_B;
      end
      GAP_B: begin
        if (expired) begin
          fire_b   = b_q;
          cnt_nx   = SETUP_LOAD;
          state_nx = GAP_CLK;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      GAP_CLK: begin
        if (expired) begin
          fire_clk = 1'b1;
          cnt_nx   = RESP_LOAD;
          state_nx = WINDOW;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      WINDOW: begin
        if (expired) begin
          finish   = 1'b1;
          state_nx = REPORT;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      REPORT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Window toggles saturate at 2: "more than one" is all the report needs.
  // A toggle seen during REPORT belongs to the next report, so it re-arms
  // the spurious flag in the same cycle the old one is cleared.
  always_comb begin
    tog_cnt_nx = tog_cnt;
    if (state == WINDOW) begin
      if (toggle && (tog_cnt != 2'd2)) tog_cnt_nx = tog_cnt + 2'd1;
    end else if (state == REPORT) begin
      tog_cnt_nx = 2'd0;
    end
    spur_nx = ((state == REPORT) ? 1'b0 : spur) | (toggle && (state != WINDOW));
    out_nx  = (tog_cnt_nx == 2'd1);
    exp_nx  = a_q & b_q;
    err_nx  = (out_nx != exp_nx) || (tog_cnt_nx == 2'd2) || spur;
  end

  // NOTE: out_q is deliberately outside the reset branch: it always tracks
  // sfq_out, so the reset edge loads the live level and raises no toggle.
  always_ff @(posedge clk) out_q <= sfq_out;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      sfq_a      <= 1'b0;
      sfq_b      <= 1'b0;
      sfq_clk    <= 1'b0;
      tog_cnt    <= 2'd0;
      spur       <= 1'b0;
      res_valid  <= 1'b0;
      res_out    <= 1'b0;
      res_exp    <= 1'b0;
      res_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sfq_a     <= sfq_a ^ fire_a;
      sfq_b     <= sfq_b ^ fire_b;
      sfq_clk   <= sfq_clk ^ fire_clk;
      tog_cnt   <= tog_cnt_nx;
      spur      <= spur_nx;
      res_valid <= finish;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      if (finish) begin
        res_out    <= out_nx;
        res_exp    <= exp_nx;
        res_err    <= err_nx;
        err_sticky <= err_sticky | err_nx;
      end
    end
  end

endmodule

// File: tb/tb_sfq_and_driver.sv
// tb_sfq_and_driver
//   Drives sfq_and_driver (default timing) with directed and random operand
//   pairs against a behavioural gate model. A scoreboard queue holds the
//   expected report for each accepted pair; a monitor pops it on res_valid.
//   A second instance with all timing parameters at 1 covers the minimum
//   spacing case.
module tb_sfq_and_driver;

  localparam int AB = 5;
  localparam int SU = 8;
  localparam int RS = 12;
  // Cycle (after the accept edge) in which res_valid is observed high.
  localparam int RV_OFF = 1 + AB + SU + RS;

  localparam int M_NORMAL  = 0;  // gate toggles once in window if a & b
  localparam int M_MISSING = 1;  // gate never toggles
  localparam int M_DOUBLE  = 2;  // gate toggles twice in window
  localparam int M_EARLY   = 3;  // extra toggle near T+3, plus normal behaviour
  localparam int M_RAISE   = 4;  // drive sfq_out high early (reset test)

  typedef struct {
    int t;
    bit a, b, out, exp, err, sticky;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0;
  logic in_ready, sfq_a, sfq_b, sfq_clk;
  logic sfq_out = 1'b0;
  logic res_valid, res_out, res_exp, res_err, err_sticky;

  logic f_in_valid = 1'b0, f_in_a = 1'b0, f_in_b = 1'b0;
  logic f_in_ready, f_sfq_a, f_sfq_b, f_sfq_clk;
  logic f_sfq_out = 1'b0;
  logic f_res_valid, f_res_out, f_res_exp, f_res_err, f_err_sticky;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int cur_mode = M_NORMAL;
  int cur_t = -1000;
  int cur_off = 8;
  int last_t = -1000;
  int a_last = -1000, b_last = -1000, c_last = -1000;
  bit sticky_m = 1'b0;
  exp_t sb[$];

  sfq_and_driver #(.AB_SEP_CYC(AB), .SETUP_CYC(SU), .RESP_CYC(RS)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .sfq_a(sfq_a), .sfq_b(sfq_b), .sfq_clk(sfq_clk),
    .sfq_out(sfq_out), .res_valid(res_valid), .res_out(res_out),
    .res_exp(res_exp), .res_err(res_err), .err_sticky(err_sticky)
  );

  sfq_and_driver #(.AB_SEP_CYC(1), .SETUP_CYC(1), .RESP_CYC(1)) u_fast (
    .clk(clk), .rst(rst), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .in_a(f_in_a), .in_b(f_in_b), .sfq_a(f_sfq_a), .sfq_b(f_sfq_b),
    .sfq_clk(f_sfq_clk), .sfq_out(f_sfq_out), .res_valid(f_res_valid),
    .res_out(f_res_out), .res_exp(f_res_exp), .res_err(f_res_err),
    .err_sticky(f_err_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Reference: count gate toggles that land inside vs outside the window,
  // then apply the reporting rules directly.
  function automatic exp_t model(input bit a, input bit b, input int mode, input int t);
    exp_t e;
    int win, outside;
    win = 0;
    outside = 0;
    case (mode)
      M_NORMAL: win = (a && b) ? 1 : 0;
      M_DOUBLE: win = 2;
      M_EARLY: begin win = (a && b) ? 1 : 0; outside = 1; end
      default: win = 0;
    endcase
    e.t   = t;
    e.a   = a;
    e.b   = b;
    e.out = (win == 1);
    e.exp = a && b;
    e.err = (e.out != e.exp) || (win > 1) || (outside > 0);
    sticky_m = sticky_m || e.err;
    e.sticky = sticky_m;
    return e;
  endfunction

  // Gate model and line observer.
  initial begin
    logic pa, pb, pc;
    bit a_seen, b_seen;
    int f1, f2;
    pa = 1'b0; pb = 1'b0; pc = 1'b0;
    a_seen = 0; b_seen = 0; f1 = -1; f2 = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_seen = 0; b_seen = 0; f1 = -1; f2 = -1;
      end else begin
        if (sfq_a != pa) begin a_last = cyc; a_seen = 1; end
        if (sfq_b != pb) begin b_last = cyc; b_seen = 1; end
        if (sfq_clk != pc) begin
          c_last = cyc;
          if (cur_mode == M_DOUBLE) begin
            f1 = cyc + 2;
            f2 = cyc + 5;
          end else if ((cur_mode == M_NORMAL || cur_mode == M_EARLY) && a_seen && b_seen) begin
            f1 = cyc + cur_off;
          end
          a_seen = 0;
          b_seen = 0;
        end
        if (cur_mode == M_EARLY && cyc == cur_t + 2) sfq_out = ~sfq_out;
        if (cur_mode == M_RAISE && cyc == cur_t + 2) sfq_out = 1'b1;
        if (cyc == f1) sfq_out = ~sfq_out;
        if (cyc == f2) sfq_out = ~sfq_out;
      end
      pa = sfq_a; pb = sfq_b; pc = sfq_clk;
    end
  end

  // Monitor: compares every report against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && res_valid) begin
        if (sb.size() == 0) begin
          check("res_valid_unexpected", res_valid, 0);
        end else begin
          e = sb.pop_front();
          check("res_out", res_out, e.out);
          check("res_exp", res_exp, e.exp);
          check("res_err", res_err, e.err);
          check("err_sticky", err_sticky, e.sticky);
          check("ready_in_report", in_ready, 0);
          check("res_valid_time", cyc - e.t, RV_OFF);
          check("clk_time", c_last - e.t, 1 + AB + SU);
          if (e.a) check("a_time", a_last - e.t, 1);
          else     check("a_quiet", a_last < e.t, 1);
          if (e.b) check("b_time", b_last - e.t, 1 + AB);
          else     check("b_quiet", b_last < e.t, 1);
        end
      end
    end
  end

  task automatic send(input bit a, input bit b, input int mode, input int off,
                      input bit chk_gap, input bit push);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_timeout", waited < 100, 1);
    cur_mode = mode;
    cur_off  = off;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
    cur_t = cyc;
    if (chk_gap) check("accept_spacing", cyc - last_t, RV_OFF + 2);
    last_t = cyc;
    if (push) sb.push_back(model(a, b, mode, cyc));
  endtask

  initial begin
    int t0, fa, fb, fc, frv;
    bit fo, fe, fr;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_sfq", {sfq_a, sfq_b, sfq_clk}, 0);
    check("rst_res", {res_valid, res_out, res_exp, res_err, err_sticky}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // Directed: (1,1), then the three other pairs back to back.
    send(1, 1, M_NORMAL, 8, 0, 1);
    send(1, 0, M_NORMAL, 8, 1, 1);
    send(0, 1, M_NORMAL, 8, 1, 1);
    send(0, 0, M_NORMAL, 8, 1, 1);
    // Error cases: missing output, double toggle, early spurious toggle.
    send(1, 1, M_MISSING, 8, 1, 1);
    send(0, 0, M_DOUBLE, 8, 1, 1);
    send(1, 1, M_EARLY, 8, 1, 1);
    send(0, 1, M_EARLY, 8, 1, 1);
    // Window edges.
    send(1, 1, M_NORMAL, 0, 1, 1);
    send(1, 1, M_NORMAL, RS - 1, 1, 1);

    // Reset mid-transaction with sfq_out driven high; pair is abandoned.
    send(1, 1, M_RAISE, 8, 1, 0);
    t0 = cur_t;
    while (cyc < t0 + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sfq", {sfq_a, sfq_b, sfq_clk}, 0);
    check("midrst_res", {res_valid, res_out, res_exp, res_err, err_sticky}, 0);
    check("midrst_ready", in_ready, 0);
    rst = 1'b0;
    sticky_m = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", in_ready, 1);
    send(1, 1, M_NORMAL, 8, 0, 1);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      send(1'($urandom), 1'($urandom), $urandom_range(0, 3),
           $urandom_range(0, RS - 1), gap == 0, 1);
    end

    // Drain the scoreboard.
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);

    // Minimum-spacing instance: window of one cycle, toggle lands on it.
    fa = -1; fb = -1; fc = -1; frv = -1; fo = 0; fe = 0; fr = 0;
    check("fast_ready", f_in_ready, 1);
    f_in_valid = 1'b1;
    f_in_a = 1'b1;
    f_in_b = 1'b1;
    @(negedge clk);
    f_in_valid = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 8; k++) begin
      logic pa, pb, pc;
      pa = f_sfq_a; pb = f_sfq_b; pc = f_sfq_clk;
      @(negedge clk);
      if (f_sfq_a != pa) fa = cyc;
      if (f_sfq_b != pb) fb = cyc;
      if (f_sfq_clk != pc) begin
        fc = cyc;
        f_sfq_out = ~f_sfq_out;
      end
      if (f_res_valid && frv < 0) begin
        frv = cyc;
        fo = f_res_out;
        fe = f_res_exp;
        fr = f_res_err;
      end
    end
    check("fast_a_time", fa - t0, 1);
    check("fast_b_time", fb - t0, 2);
    check("fast_clk_time", fc - t0, 3);
    check("fast_res_valid_time", frv - t0, 4);
    check("fast_res", {fo, fe, fr}, 3'b110);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
